// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the fifo_wr_arb write arbiter.
//   - arb_state_e   : arbitration state (ARB = free round-robin, HOLD = locked owner)
//   - ARB_NREQ      : default requester count, ARB_IDX_W its index width
//   - ARB_MAX_NREQ  : largest supported requester count (index helper width)
//   - onehot_to_idx : converts a one-hot grant vector into a binary index
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int ARB_NREQ      = 4;
  localparam int ARB_IDX_W     = $clog2(ARB_NREQ);
  localparam int ARB_MAX_NREQ  = 8;
  localparam int ARB_MAX_IDX_W = $clog2(ARB_MAX_NREQ);

  // OR-reduction of the set bit positions; exact for one-hot or zero input.
  function automatic logic [ARB_MAX_IDX_W-1:0] onehot_to_idx(
    input logic [ARB_MAX_NREQ-1:0] oh
  );
    logic [ARB_MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < ARB_MAX_NREQ; i++) begin
      if (oh[i]) r = r | ARB_MAX_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select using a masked priority scheme.
// Ports:
//   req [NREQ]  : request vector
//   ptr [IDX_W] : highest-priority position for this cycle
//   en          : grant enable; gnt is zero when low
//   gnt [NREQ]  : one-hot grant (or zero)
//   idx [IDX_W] : binary index of the granted requester
import fifo_arb_pkg::*;

module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] sel;

  // Positions at or above ptr win first; if none of them request, the
  // search wraps to the lowest requesting position overall.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign masked = req & mask;
  assign pick   = (|masked) ? masked : req;
  assign sel    = pick & (~pick + NREQ'(1));   // isolate lowest set bit
  assign gnt    = en ? sel : '0;
  assign idx    = IDX_W'(onehot_to_idx(ARB_MAX_NREQ'(gnt)));

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing the write port of a DEPTH-word FIFO
// among NREQ valid/ready producers, with a registered write stage and a
// credit counter (level) that prevents over-filling.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_data/req_ready : producer handshakes (req_ready combinational)
//   fifo_wr_en/fifo_data_in      : registered write port toward the FIFO
//   fifo_rd_en/fifo_empty        : FIFO consumer monitor, used to return credits
//   level                        : accepted words not yet read (incl. in-flight)
//   grant_id                     : index of the last accepted requester
//   req_lock (only with FIFO_ARB_LOCK_EN) : per-requester lock request
// Optional feature macro: FIFO_ARB_LOCK_EN adds the HOLD (locked owner) state.
import fifo_arb_pkg::*;

module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_rd_en,
  input  logic                     fifo_empty,
  output logic [ADDR:0]            level,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [ADDR:0] FULL_LEVEL = (ADDR+1)'(DEPTH);

  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [ADDR:0]    level_reg, level_next;
  logic             wr_en_reg;
  logic [WIDTH-1:0] data_reg;
  logic [IDX_W-1:0] grant_id_reg;

  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] win_idx;
  logic             can_write;
  logic             arb_en;
  logic             accept;
  logic             rd_cnt;
  logic             ptr_adv;

  assign can_write = (level_reg < FULL_LEVEL);
  // Gating with rst keeps req_ready low for the whole reset interval.
  assign arb_en    = can_write & rst;
  assign accept    = |gnt;
  assign rd_cnt    = fifo_rd_en & ~fifo_empty;

`ifdef FIFO_ARB_LOCK_EN
  arb_state_e       state_reg, state_next;
  logic [IDX_W-1:0] owner_reg, owner_next;

  // While locked only the owner may compete.
  assign arb_req = (state_reg == HOLD) ? (req_valid & (NREQ'(1) << owner_reg)) : req_valid;
  assign ptr_adv = accept && (state_reg == ARB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ARB;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      ARB: begin
        if (accept && req_lock[win_idx]) begin
          state_next = HOLD;
          owner_next = win_idx;
        end
      end
      HOLD: begin
        // Owner walking away or sending its unlocked word ends the lock.
        if (!req_valid[owner_reg])
          state_next = ARB;
        else if (accept && !req_lock[owner_reg])
          state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end
`else
  assign arb_req = req_valid;
  assign ptr_adv = accept;
`endif

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req (arb_req),
    .ptr (rr_ptr_reg),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign req_ready = gnt;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (ptr_adv)
      rr_ptr_next = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);
  end

  // Credits: an accept takes one, a counted read returns one; both cancel.
  always_comb begin
    level_next = level_reg;
    if (accept && !rd_cnt)
      level_next = level_reg + (ADDR+1)'(1);
    else if (!accept && rd_cnt && level_reg != '0)
      level_next = level_reg - (ADDR+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg   <= '0;
      level_reg    <= '0;
      wr_en_reg    <= 1'b0;
      data_reg     <= '0;
      grant_id_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      level_reg  <= level_next;
      wr_en_reg  <= accept;
      if (accept) begin
        data_reg     <= req_data[win_idx*WIDTH +: WIDTH];
        grant_id_reg <= win_idx;
      end
    end
  end

  assign fifo_wr_en   = wr_en_reg;
  assign fifo_data_in = data_reg;
  assign level        = level_reg;
  assign grant_id     = grant_id_reg;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed self-checking bench for fifo_wr_arb (NREQ=4,
// WIDTH=8, DEPTH=16). Lock scenario included when FIFO_ARB_LOCK_EN is defined.
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
`ifdef FIFO_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic [4:0]  level;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  fifo_wr_arb #(.NREQ(4), .WIDTH(8), .DEPTH(16), .ADDR(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
`ifdef FIFO_ARB_LOCK_EN
    .req_lock     (req_lock),
`endif
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_empty   (fifo_empty),
    .level        (level),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 4'b1111;
    req_data   = 32'hA3A2A1A0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
`ifdef FIFO_ARB_LOCK_EN
    req_lock   = 4'b0000;
`endif
    #2;
    // Reset values, with requests pending to show req_ready is gated.
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_data",  32'(fifo_data_in), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_gid",   32'(grant_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;

    // All four valid for 8 cycles: strict rotation 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      #2;
      check("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      cyc();
      check("rr_wr_en", 32'(fifo_wr_en), 32'd1);
      check("rr_data",  32'(fifo_data_in), 32'(8'hA0 + k % 4));
      check("rr_gid",   32'(grant_id), 32'(k % 4));
      check("rr_level", 32'(level), 32'(k + 1));
    end
    req_valid = 4'b0000;
    #2;
    check("idle_ready", 32'(req_ready), 32'd0);
    cyc();
    check("idle_wr_en", 32'(fifo_wr_en), 32'd0);
    check("idle_data",  32'(fifo_data_in), 32'hA3);
    check("idle_level", 32'(level), 32'd8);

    // Level 8: accept from requester 0 plus a counted read in the same cycle.
    req_valid  = 4'b0001;
    req_data   = 32'hA3A2A155;
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b0;
    #2;
    check("both_ready", 32'(req_ready), 32'b0001);
    cyc();
    check("both_level", 32'(level), 32'd8);
    check("both_data",  32'(fifo_data_in), 32'h55);
    req_valid = 4'b0000;
    for (int k = 0; k < 8; k++) cyc();
    check("drain1_level", 32'(level), 32'd0);
    fifo_empty = 1'b1;
    cyc();
    check("rd_empty_level", 32'(level), 32'd0);
    fifo_rd_en = 1'b0;

    // Fill from requester 2 alone: exactly 16 accepts.
    req_valid = 4'b0100;
    req_data  = 32'hA3C2A1A0;
    for (int k = 0; k < 16; k++) begin
      #2;
      check("fill_ready", 32'(req_ready), 32'b0100);
      cyc();
      check("fill_level", 32'(level), 32'(k + 1));
    end
    #2;
    check("full_ready", 32'(req_ready), 32'd0);
    cyc();
    check("full_wr_en", 32'(fifo_wr_en), 32'd0);
    check("full_level", 32'(level), 32'd16);

    // One counted read at full re-opens exactly one grant a cycle later.
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b0;
    #2;
    check("rd_full_ready", 32'(req_ready), 32'd0);
    cyc();
    check("rd_full_level", 32'(level), 32'd15);
    check("rd_full_wr_en", 32'(fifo_wr_en), 32'd0);
    fifo_rd_en = 1'b0;
    #2;
    check("reopen_ready", 32'(req_ready), 32'b0100);
    cyc();
    check("reopen_level", 32'(level), 32'd16);
    check("reopen_wr_en", 32'(fifo_wr_en), 32'd1);
    #2;
    check("refull_ready", 32'(req_ready), 32'd0);
    req_valid  = 4'b0000;
    fifo_rd_en = 1'b1;
    for (int k = 0; k < 16; k++) cyc();
    check("drain2_level", 32'(level), 32'd0);
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;

    // rr_ptr is 3 now: burst of 5 goes 3,0,1,2,3, then reset mid-burst.
    req_valid = 4'b1111;
    req_data  = 32'hA3A2A1A0;
    for (int k = 0; k < 5; k++) begin
      #2;
      check("burst_ready", 32'(req_ready), 32'(4'b0001 << ((k + 3) % 4)));
      cyc();
    end
    check("burst_level", 32'(level), 32'd5);
    check("burst_wr_en", 32'(fifo_wr_en), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_gid",   32'(grant_id), 32'd0);
    cyc();
    rst = 1'b1;
    #2;
    check("restart_ready", 32'(req_ready), 32'b0001);
    cyc();
    check("restart_gid",   32'(grant_id), 32'd0);
    check("restart_level", 32'(level), 32'd1);
    check("restart_data",  32'(fifo_data_in), 32'hA0);

`ifdef FIFO_ARB_LOCK_EN
    // rr_ptr is 1: requester 1 locks for two words, releases on the third.
    req_lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req_lock = 4'b0000;
      #2;
      check("lock_ready", 32'(req_ready), 32'b0010);
      cyc();
      check("lock_gid", 32'(grant_id), 32'd1);
    end
    #2;
    check("unlock_ready", 32'(req_ready), 32'b0100);
    cyc();
    check("unlock_gid", 32'(grant_id), 32'd2);
`endif

    req_valid = 4'b0000;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares the single write port of the team's `fifo` (DEPTH 16, WIDTH 8) between `NREQ` producers. Each producer uses a valid/ready handshake. The block registers the winning word onto `fifo_wr_en`/`fifo_data_in` and tracks FIFO occupancy itself through a credit counter, so it never over-fills the FIFO despite the registered write stage. It sits directly in front of `fifo`, and its write outputs connect straight to that module's `wr_en`/`data_in` ports.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: data word width; must match the FIFO.
- `DEPTH`, 16: FIFO capacity in words; must match the FIFO.
- `ADDR`, 4: log2(`DEPTH`).

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: bit i means requester i has a word.
- `req_data` in `NREQ*WIDTH`: requester i's word is at bits [i*WIDTH +: WIDTH].
- `req_ready` out `NREQ`: one-hot or zero; combinational grant.
- `fifo_wr_en` out 1: registered write strobe to the FIFO.
- `fifo_data_in` out `WIDTH`: registered write data to the FIFO.
- `fifo_rd_en` in 1: copy of the FIFO consumer's `rd_en`, used for monitoring only.
- `fifo_empty` in 1: the FIFO's `empty` flag.
- `level` out `ADDR+1`: accepted words not yet read (includes the in-flight write), range 0..`DEPTH`.
- `grant_id` out `$clog2(NREQ)`: index of the last accepted requester (registered).

## Operation
- Credit rule: `can_write = (level < DEPTH)`.
- Grant rule: when `can_write` is 1, grant the first i with `req_valid[i]`=1, searching i = `rr_ptr`, `rr_ptr`+1, … mod `NREQ`.
  - `req_ready[i]` is 1 only for that winner; all bits are 0 when `can_write` is 0 or when no request is valid.
- Accept: `req_valid[i] && req_ready[i]`. On the next edge:
  - `fifo_wr_en` is set to 1 and `fifo_data_in` takes the winner's word.
  - `grant_id` takes i.
  - `rr_ptr` becomes (i+1) mod `NREQ`.
- With no accept, `fifo_wr_en` is set to 0 on the next edge and `fifo_data_in` holds its value.
- A read is counted when `fifo_rd_en && !fifo_empty`.
- `level` update per edge:
  - accept only: +1.
  - counted read only: −1.
  - accept and counted read together: unchanged.
  - neither: unchanged.
- `level` never exceeds `DEPTH` and never goes below 0.
- `rr_ptr` advances only on an accept.
- Requesters must hold `req_valid` and `req_data` stable until accepted. A requester that drops `req_valid` simply loses its turn.
- States:
  - ARB: free arbitration as described above.
  - HOLD: exists only under `FIFO_ARB_LOCK_EN` (see Configuration). Without the macro the block is permanently in ARB.

## Timing
- Values after reset:
  - `fifo_wr_en`=0, `fifo_data_in`=0, `level`=0, `grant_id`=0.
  - `rr_ptr`=0, state=ARB.
  - `req_ready`=0 while `rst` is low.
- Requester-to-FIFO latency: a word accepted at edge t is written into the FIFO at edge t+1.
- Throughput: one word per cycle while `level<DEPTH`.
- Full boundary: the accept that takes `level` from 15 to 16 is allowed. At `level`=16, `req_ready` is 0 in the following cycle.
- Consequence: `fifo_wr_en` is never asserted when the FIFO is full, so the FIFO's `full` flag is not needed as an input.
- A counted read at `level`=16 re-opens grants one cycle later.
- Reset asserted mid-operation: all state clears immediately, and any in-flight write is dropped. The FIFO must be reset together with this block.

## Configuration
- `FIFO_ARB_LOCK_EN` defined:
  - Adds input `req_lock` of width `NREQ`.
  - An accept from requester i with `req_lock[i]`=1 enters HOLD with owner=i.
  - In HOLD only the owner can be granted, and `rr_ptr` does not advance.
  - HOLD returns to ARB on an owner accept with `req_lock[i]`=0 (that word is still written), or if the owner drops `req_valid`.
  - Reset forces ARB.
- `FIFO_ARB_LOCK_EN` undefined: the `req_lock` port is absent, there is no HOLD state, and every accept advances `rr_ptr`.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {ARB, HOLD}.
  - `NREQ`-dependent index width localparam.
  - one-hot-to-index function.
- Sub-module `rr_arbiter`:
  - combinational masked-priority select.
  - inputs: request vector, `rr_ptr`, enable.
  - outputs: one-hot grant and winner index.
- Top-level registers: `rr_ptr`, `level`, the write stage, `grant_id`, and the lock state.

## Test plan
- Reset, then assert `req_valid`=4'b1111 with data 0xA0..0xA3 held for 8 cycles and no reads.
  - Required: accepts in order 0,1,2,3,0,1,2,3.
  - Required: `fifo_wr_en` asserted one cycle after each accept; `level` reaches 8.
- Fill from requester 2 alone, with no reads.
  - Required: exactly 16 accepts, then `req_ready`=0 and `level`=16.
  - Required: no `fifo_wr_en` pulse while the FIFO is full.
- At `level`=16, pulse `fifo_rd_en` for one cycle with `fifo_empty`=0.
  - Required: `level`=15, and one further accept follows the next cycle.
- At `level`=8, accept and counted read in the same cycle.
  - Required: `level` stays 8.
  - Also: `fifo_rd_en`=1 with `fifo_empty`=1 at `level`=0 → `level` stays 0.
- Assert `rst`=0 mid-burst at `level`=5.
  - Required immediately: `level`=0, `fifo_wr_en`=0, `req_ready`=0.
  - Required after release: arbitration restarts at requester 0.
- With `FIFO_ARB_LOCK_EN`: requester 1 sends 3 words with `req_lock`=1,1,0 while all requesters are valid.
  - Required: grants 1,1,1, then 2.
